// File: rtl/cpu_run_monitor.sv
// Run controller/checker around a RISC-V core: sequences core reset, counts run cycles and retired writes,
// folds write-backs into a signature and declares pass/fail once the core halts or the run times out.
module cpu_run_monitor #(
  parameter int          XLEN        = 32,
  parameter int          RST_CYCLES  = 2,
  parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
  parameter int          HALT_REPEAT = 4,
  parameter int          MAX_CYCLES  = 300,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             wb_en,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [XLEN-1:0]  expected_sig,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [XLEN-1:0]  signature,
  output logic [XLEN-1:0]  halt_pc
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int HW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {IDLE, RSTH, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   rst_cnt;
  logic [HW-1:0]   rep_cnt;
  logic            first;
  logic [XLEN-1:0] prev_pc;
  logic [XLEN-1:0] exp_sig;

  logic             start_ok;
  logic             qual;
  logic             halt_hit;
  logic             tmo_hit;
  logic [CNT_W-1:0] cyc_inc;
  logic [HW-1:0]    rep_inc;
  logic [XLEN-1:0]  sig_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [XLEN-1:0] sig_fold(input logic [XLEN-1:0] s, input logic [XLEN-1:0] d);
    return {s[XLEN-2:0], s[XLEN-1]} ^ d;
  endfunction

  // Values this RUN cycle would commit; halt_hit/tmo_hit decide the exit.
  always_comb begin
    cyc_inc  = sat_inc(cycle_count);
    sig_inc  = wb_en ? sig_fold(signature, wb_data) : signature;
    qual     = (instr == HALT_INSTR) || (!first && (pc == prev_pc));
    rep_inc  = qual ? rep_cnt + HW'(1) : '0;
    halt_hit = (rep_inc == HW'(HALT_REPEAT));
    tmo_hit  = !halt_hit && (cyc_inc == CNT_W'(MAX_CYCLES));
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RSTH;
        start_ok  = 1'b1;
      end
      RSTH:       if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN:        if (halt_hit || tmo_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign core_rst = (state == IDLE) || (state == RSTH);
  assign running  = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      rep_cnt      <= '0;
      first        <= 1'b1;
      cycle_count  <= '0;
      retire_count <= '0;
      signature    <= '0;
      halt_pc      <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: if (start_ok) begin
          rst_cnt      <= '0;
          cycle_count  <= '0;
          retire_count <= '0;
          signature    <= '0;
          halt_pc      <= '0;
          pass         <= 1'b0;
          timeout      <= 1'b0;
        end
        RSTH: begin
          rst_cnt <= rst_cnt + RW'(1);
          rep_cnt <= '0;
          first   <= 1'b1;
        end
        RUN: begin
          cycle_count <= cyc_inc;
          if (wb_en) retire_count <= sat_inc(retire_count);
          signature <= sig_inc;
          rep_cnt   <= rep_inc;
          first     <= 1'b0;
          if (halt_hit) begin
            halt_pc <= pc;
            pass    <= (sig_inc == exp_sig);
          end
          if (tmo_hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Golden signature and previous PC carry no reset: both are written before they are consulted.
  always_ff @(posedge clk) begin
    if (start_ok) exp_sig <= expected_sig;
    if (state == RUN) prev_pc <= pc;
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed scenarios plus randomized runs, all checked every cycle
// against a behavioural model of the run/halt/timeout rules.
module tb_cpu_run_monitor;

  localparam int          RSTC = 2;
  localparam int          HREP = 4;
  localparam int          MAXC = 300;
  localparam logic [31:0] HALT = 32'h0000006F;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int P_IDLE = 0, P_RSTH = 1, P_RUN = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        wb_en = 1'b0;
  logic [31:0] wb_data = '0;
  logic [31:0] expected_sig = '0;
  logic        core_rst, running, done, pass, timeout;
  logic [15:0] cycle_count, retire_count;
  logic [31:0] signature, halt_pc;

  int n_checks = 0;
  int n_fail = 0;

  cpu_run_monitor dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .instr(instr), .wb_en(wb_en),
    .wb_data(wb_data), .expected_sig(expected_sig), .core_rst(core_rst), .running(running),
    .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .retire_count(retire_count), .signature(signature), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, updated from the inputs seen at each rising edge.
  int          m_phase = P_IDLE;
  int          m_rsth, m_cycles, m_retires, m_run;
  logic [31:0] m_sig, m_exp, m_halt_pc, m_prev;
  bit          m_first, m_pass, m_tmo;
  bit          m_valid = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_begin_run();
    m_phase   = P_RSTH;
    m_rsth    = 0;
    m_cycles  = 0;
    m_retires = 0;
    m_sig     = 0;
    m_halt_pc = 0;
    m_pass    = 0;
    m_tmo     = 0;
    m_exp     = expected_sig;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_cycles = 0; m_retires = 0; m_sig = 0;
      m_halt_pc = 0; m_pass = 0; m_tmo = 0; m_valid = 1;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (start) model_begin_run();
        P_RSTH: begin
          m_rsth++;
          if (m_rsth == RSTC) begin m_phase = P_RUN; m_first = 1; m_run = 0; end
        end
        default: begin
          m_cycles++;
          if (wb_en) begin
            m_retires++;
            m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ wb_data;
          end
          if (instr == HALT || (!m_first && pc == m_prev)) m_run++;
          else m_run = 0;
          m_prev  = pc;
          m_first = 0;
          if (m_run >= HREP) begin
            m_phase = P_DONE; m_halt_pc = pc; m_pass = (m_sig == m_exp);
          end else if (sat16(m_cycles) == MAXC) begin
            m_phase = P_DONE; m_tmo = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("core_rst",     core_rst,     (m_phase == P_IDLE || m_phase == P_RSTH));
      chk("running",      running,      (m_phase == P_RUN));
      chk("done",         done,         (m_phase == P_DONE));
      chk("pass",         pass,         m_pass);
      chk("timeout",      timeout,      m_tmo);
      chk("cycle_count",  cycle_count,  16'(sat16(m_cycles)));
      chk("retire_count", retire_count, 16'(sat16(m_retires)));
      chk("signature",    signature,    m_sig);
      chk("halt_pc",      halt_pc,      m_halt_pc);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc(input logic [31:0] p, input logic [31:0] i, input logic we, input logic [31:0] d);
    pc = p; instr = i; wb_en = we; wb_data = d;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] e);
    start = 1'b1; expected_sig = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!running && n < 20) begin tick(); n++; end
    chk("wait_run", running, 1'b1);
  endtask

  logic [31:0] pcv;
  int n;

  initial begin
    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_cycles", cycle_count, 16'd0);
    chk("rst_retires", retire_count, 16'd0);
    chk("rst_sig", signature, 32'd0);
    rst = 1'b0;
    tick();

    // Core reset released exactly two cycles after start is taken
    pulse_start(32'h4);
    n = 0;
    while (core_rst && n < 10) begin tick(); n++; end
    chk("core_rst_release", n, 2);

    // Write-back folding then halt on jal x0,0 at 0x40
    cyc(32'h0, NOP, 1'b1, 32'h1); chk("sig_w1", signature, 32'h1);
    cyc(32'h4, NOP, 1'b1, 32'h2); chk("sig_w2", signature, 32'h0);
    cyc(32'h8, NOP, 1'b1, 32'h4); chk("sig_w3", signature, 32'h4);
    chk("retire_3", retire_count, 16'd3);
    repeat (3) cyc(32'h40, HALT, 1'b0, 32'h0);
    chk("no_halt_yet", done, 1'b0);
    cyc(32'h40, HALT, 1'b0, 32'h0);
    chk("halt_done", done, 1'b1);
    chk("halt_pass", pass, 1'b1);
    chk("halt_pc", halt_pc, 32'h40);
    chk("halt_tmo", timeout, 1'b0);
    chk("halt_cycles", cycle_count, 16'd7);
    repeat (3) cyc(32'h44, NOP, 1'b1, 32'hFFFF);
    chk("done_hold_sig", signature, 32'h4);

    // Timeout with a free-running PC
    pulse_start(32'h0);
    wait_run();
    pcv = 32'h100;
    n = 0;
    while (!done && n < 400) begin
      cyc(pcv, NOP, 1'($urandom_range(0, 1)), $urandom);
      pcv += 4; n++;
    end
    chk("tmo_done", done, 1'b1);
    chk("tmo_cycles", cycle_count, 16'd300);
    chk("tmo_flag", timeout, 1'b1);
    chk("tmo_pass", pass, 1'b0);
    chk("tmo_halt_pc", halt_pc, 32'h0);

    // Signature mismatch, then rerun clears results
    pulse_start(32'hDEADBEEF);
    wait_run();
    cyc(32'h10, NOP, 1'b1, 32'h11);
    cyc(32'h14, NOP, 1'b1, 32'h22);
    repeat (4) cyc(32'h80, HALT, 1'b0, 32'h0);
    chk("mis_done", done, 1'b1);
    chk("mis_pass", pass, 1'b0);
    chk("mis_tmo", timeout, 1'b0);
    chk("mis_halt_pc", halt_pc, 32'h80);
    pulse_start(32'h0);
    chk("rerun_cycles", cycle_count, 16'd0);
    chk("rerun_sig", signature, 32'd0);
    chk("rerun_core_rst", core_rst, 1'b1);
    chk("rerun_done", done, 1'b0);

    // Reset in the middle of a run, with a start in the same cycle
    wait_run();
    pcv = 32'h200;
    repeat (50) begin cyc(pcv, NOP, 1'b1, $urandom); pcv += 4; end
    chk("mid_cycles", cycle_count, 16'd50);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("midrst_core_rst", core_rst, 1'b1);
    chk("midrst_cycles", cycle_count, 16'd0);
    chk("midrst_sig", signature, 32'd0);
    chk("midrst_running", running, 1'b0);
    tick();
    chk("midrst_idle", core_rst, 1'b1);

    // Randomized runs: stalls, halt opcodes, stray starts and resets
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
      pulse_start($urandom);
      pcv = $urandom & 32'h0000FFFC;
      for (int c = 0; c < 350; c++) begin
        if ($urandom_range(0, 2) != 0) pcv += 4;
        start = ($urandom_range(0, 40) == 0);
        rst   = ($urandom_range(0, 300) == 0);
        cyc(pcv, ($urandom_range(0, 9) == 0) ? HALT : $urandom,
            1'($urandom_range(0, 1)), $urandom);
        start = 1'b0; rst = 1'b0;
        if (done && $urandom_range(0, 3) == 0) break;
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
